// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control
// Brief    : Multicycle MIPS control FSM with ALU decoder (lw, sw, R, beq,
//            addi, j) driving datapath selects, strobes and PC enable.
// Revision : 1.0
// ============================================================================
module mips_multicycle_control #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       Illegal,
    output logic [3:0] State
);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXECUTE  = 4'd6;
    localparam logic [3:0] c_ALUWB    = 4'd7;
    localparam logic [3:0] c_BRANCH   = 4'd8;
    localparam logic [3:0] c_ADDIEX   = 4'd9;
    localparam logic [3:0] c_ADDIWB   = 4'd10;
    localparam logic [3:0] c_JUMP     = 4'd11;
    localparam logic [3:0] c_TRAP     = 4'd12;

    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_funct_ok;
    logic [1:0] w_aluop;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_funct_ok = 1'b0;
        case (Funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: w_funct_ok = 1'b1;
            default:                                               w_funct_ok = 1'b0;
        endcase
    end

    // Illegal opcodes are only resolved in DECODE; later states trust the IR.
    always_comb begin
        w_next = c_FETCH;
        case (r_state)
            c_FETCH:  w_next = c_DECODE;
            c_DECODE: begin
                case (Op)
                    c_OP_LW, c_OP_SW: w_next = c_MEMADR;
                    c_OP_RTYPE:       w_next = w_funct_ok ? c_EXECUTE
                                             : (ILLEGAL_TRAP ? c_TRAP : c_FETCH);
                    c_OP_BEQ:         w_next = c_BRANCH;
                    c_OP_ADDI:        w_next = c_ADDIEX;
                    c_OP_J:           w_next = c_JUMP;
                    default:          w_next = ILLEGAL_TRAP ? c_TRAP : c_FETCH;
                endcase
            end
            c_MEMADR:  w_next = (Op == c_OP_SW) ? c_MEMWRITE : c_MEMREAD;
            c_MEMREAD: w_next = c_MEMWB;
            c_EXECUTE: w_next = c_ALUWB;
            c_ADDIEX:  w_next = c_ADDIWB;
            c_TRAP:    w_next = c_TRAP;
            default:   w_next = c_FETCH;
        endcase
    end

    always_comb begin
        IorD       = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        w_regwrite = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        w_aluop    = 2'b00;
        PCSrc      = 2'b00;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_illegal  = 1'b0;
        case (r_state)
            c_FETCH: begin
                ALUSrcB   = 2'b01;
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
            end
            c_DECODE:   ALUSrcB = 2'b11;
            c_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            c_MEMREAD:  IorD = 1'b1;
            c_MEMWB: begin
                MemtoReg   = 1'b1;
                w_regwrite = 1'b1;
            end
            c_MEMWRITE: begin
                IorD       = 1'b1;
                w_memwrite = 1'b1;
            end
            c_EXECUTE: begin
                ALUSrcA = 1'b1;
                w_aluop = 2'b10;
            end
            c_ALUWB: begin
                RegDst     = 1'b1;
                w_regwrite = 1'b1;
            end
            c_BRANCH: begin
                ALUSrcA  = 1'b1;
                w_aluop  = 2'b01;
                PCSrc    = 2'b01;
                w_branch = 1'b1;
            end
            c_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            c_ADDIWB:   w_regwrite = 1'b1;
            c_JUMP: begin
                PCSrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            c_TRAP:     w_illegal = 1'b1;
            default:    w_illegal = 1'b0;
        endcase
    end

    always_comb begin
        ALUControl = 3'b010;
        case (w_aluop)
            2'b01:   ALUControl = 3'b110;
            2'b10: begin
                case (Funct)
                    6'b100010: ALUControl = 3'b110;
                    6'b100100: ALUControl = 3'b000;
                    6'b100101: ALUControl = 3'b001;
                    6'b101010: ALUControl = 3'b111;
                    default:   ALUControl = 3'b010;
                endcase
            end
            default: ALUControl = 3'b010;
        endcase
    end

    // Strobes are gated by reset so an aborted instruction writes nothing.
    assign MemWrite = w_memwrite & ~reset;
    assign IRWrite  = w_irwrite & ~reset;
    assign RegWrite = w_regwrite & ~reset;
    assign PCEn     = (w_pcwrite | (w_branch & Zero)) & ~reset;
    assign Illegal  = w_illegal & ~reset;
    assign State    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_control
// Brief    : Table-driven directed bench for the multicycle control FSM.
// Revision : 1.0
// ============================================================================
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Op = 6'b0;
    logic [5:0] Funct = 6'b0;
    logic       Zero = 1'b0;

    logic       a_iord, a_memw, a_irw, a_rd, a_m2r, a_rw, a_srca, a_pcen, a_ill;
    logic [1:0] a_srcb, a_pcsrc;
    logic [2:0] a_aluc;
    logic [3:0] a_state;
    logic       b_iord, b_memw, b_irw, b_rd, b_m2r, b_rw, b_srca, b_pcen, b_ill;
    logic [1:0] b_srcb, b_pcsrc;
    logic [2:0] b_aluc;
    logic [3:0] b_state;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mips_multicycle_control #(.ILLEGAL_TRAP(1'b1)) dut_trap (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(a_iord), .MemWrite(a_memw), .IRWrite(a_irw), .RegDst(a_rd),
        .MemtoReg(a_m2r), .RegWrite(a_rw), .ALUSrcA(a_srca), .ALUSrcB(a_srcb),
        .ALUControl(a_aluc), .PCSrc(a_pcsrc), .PCEn(a_pcen), .Illegal(a_ill),
        .State(a_state)
    );

    mips_multicycle_control #(.ILLEGAL_TRAP(1'b0)) dut_fetch (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(b_iord), .MemWrite(b_memw), .IRWrite(b_irw), .RegDst(b_rd),
        .MemtoReg(b_m2r), .RegWrite(b_rw), .ALUSrcA(b_srca), .ALUSrcB(b_srcb),
        .ALUControl(b_aluc), .PCSrc(b_pcsrc), .PCEn(b_pcen), .Illegal(b_ill),
        .State(b_state)
    );

    logic [19:0] act_a, act_b;
    assign act_a = {a_state, a_iord, a_memw, a_irw, a_rd, a_m2r, a_rw, a_srca,
                    a_srcb, a_aluc, a_pcsrc, a_pcen, a_ill};
    assign act_b = {b_state, b_iord, b_memw, b_irw, b_rd, b_m2r, b_rw, b_srca,
                    b_srcb, b_aluc, b_pcsrc, b_pcen, b_ill};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];

    // strb order: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA
    function automatic logic [19:0] pk(input logic [3:0] st, input logic [6:0] strb,
                                       input logic [1:0] srcb, input logic [2:0] aluc,
                                       input logic [1:0] pcsrc, input logic pcen,
                                       input logic ill);
        return {st, strb, srcb, aluc, pcsrc, pcen, ill};
    endfunction

    task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic [19:0] e);
        vec_t v;
        v.rst = r; v.op = o; v.funct = f; v.zero = z; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got state=%0d bits=%h, expected state=%0d bits=%h",
                     nm, act[19:16], act, exp[19:16], exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [19:0] e_rst, e_fetch, e_dec, e_madr, e_mrd, e_mwb, e_mwr, e_awb;
    logic [19:0] e_aex, e_awb2, e_jmp, e_trap;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

    initial begin
        e_rst   = pk(4'd0,  7'b0000000, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0);
        e_fetch = pk(4'd0,  7'b0010000, 2'b01, 3'b010, 2'b00, 1'b1, 1'b0);
        e_dec   = pk(4'd1,  7'b0000000, 2'b11, 3'b010, 2'b00, 1'b0, 1'b0);
        e_madr  = pk(4'd2,  7'b0000001, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0);
        e_mrd   = pk(4'd3,  7'b1000000, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0);
        e_mwb   = pk(4'd4,  7'b0000110, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0);
        e_mwr   = pk(4'd5,  7'b1100000, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0);
        e_awb   = pk(4'd7,  7'b0001010, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0);
        e_aex   = pk(4'd9,  7'b0000001, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0);
        e_awb2  = pk(4'd10, 7'b0000010, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0);
        e_jmp   = pk(4'd11, 7'b0000000, 2'b00, 3'b010, 2'b10, 1'b1, 1'b0);
        e_trap  = pk(4'd12, 7'b0000000, 2'b00, 3'b010, 2'b00, 1'b0, 1'b1);

        // reset held two cycles, then lw
        add(1, LW, 6'h00, 0, e_rst);
        add(1, LW, 6'h00, 0, e_rst);
        add(0, LW, 6'h00, 0, e_fetch);
        add(0, LW, 6'h00, 0, e_dec);
        add(0, LW, 6'h00, 0, e_madr);
        add(0, LW, 6'h00, 1, e_mrd);
        add(0, LW, 6'h00, 0, e_mwb);
        // sw
        add(0, SW, 6'h00, 0, e_fetch);
        add(0, SW, 6'h00, 0, e_dec);
        add(0, SW, 6'h00, 0, e_madr);
        add(0, SW, 6'h00, 0, e_mwr);
        // R-type sweep
        add(0, RT, 6'b101010, 0, e_fetch);
        add(0, RT, 6'b101010, 0, e_dec);
        add(0, RT, 6'b101010, 0, pk(4'd6, 7'b0000001, 2'b00, 3'b111, 2'b00, 1'b0, 1'b0));
        add(0, RT, 6'b101010, 0, e_awb);
        add(0, RT, 6'b100000, 0, e_fetch);
        add(0, RT, 6'b100000, 0, e_dec);
        add(0, RT, 6'b100000, 0, pk(4'd6, 7'b0000001, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0));
        add(0, RT, 6'b100000, 0, e_awb);
        add(0, RT, 6'b100010, 0, e_fetch);
        add(0, RT, 6'b100010, 0, e_dec);
        add(0, RT, 6'b100010, 0, pk(4'd6, 7'b0000001, 2'b00, 3'b110, 2'b00, 1'b0, 1'b0));
        add(0, RT, 6'b100010, 0, e_awb);
        add(0, RT, 6'b100100, 0, e_fetch);
        add(0, RT, 6'b100100, 0, e_dec);
        add(0, RT, 6'b100100, 0, pk(4'd6, 7'b0000001, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0));
        add(0, RT, 6'b100100, 0, e_awb);
        add(0, RT, 6'b100101, 0, e_fetch);
        add(0, RT, 6'b100101, 0, e_dec);
        add(0, RT, 6'b100101, 0, pk(4'd6, 7'b0000001, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0));
        add(0, RT, 6'b100101, 0, e_awb);
        // beq taken then not taken; Zero outside BRANCH must not leak into PCEn
        add(0, BEQ, 6'h00, 1, e_fetch);
        add(0, BEQ, 6'h00, 1, e_dec);
        add(0, BEQ, 6'h00, 1, pk(4'd8, 7'b0000001, 2'b00, 3'b110, 2'b01, 1'b1, 1'b0));
        add(0, BEQ, 6'h00, 0, e_fetch);
        add(0, BEQ, 6'h00, 0, e_dec);
        add(0, BEQ, 6'h00, 0, pk(4'd8, 7'b0000001, 2'b00, 3'b110, 2'b01, 1'b0, 1'b0));
        // addi then j
        add(0, ADDI, 6'h00, 0, e_fetch);
        add(0, ADDI, 6'h00, 0, e_dec);
        add(0, ADDI, 6'h00, 0, e_aex);
        add(0, ADDI, 6'h00, 1, e_awb2);
        add(0, J, 6'h00, 0, e_fetch);
        add(0, J, 6'h00, 0, e_dec);
        add(0, J, 6'h00, 0, e_jmp);
        add(0, LW, 6'h00, 0, e_fetch);

        #0;
        foreach (tbl[i]) begin
            reset = tbl[i].rst; Op = tbl[i].op; Funct = tbl[i].funct; Zero = tbl[i].zero;
            #3;
            chk($sformatf("vec%0d", i), act_a, tbl[i].exp);
            tick();
        end

        // reset asserted mid-instruction in MEMREAD (state now DECODE of lw)
        Op = LW; Zero = 1'b0;
        tick();
        chk("lw_memadr", act_a, e_madr);
        tick();
        chk("lw_memread", act_a, e_mrd);
        #2 reset = 1'b1;
        #1 chk("abort_async", act_a, e_rst);
        tick();
        chk("abort_hold1", act_a, e_rst);
        tick();
        chk("abort_hold2", act_a, e_rst);
        reset = 1'b0;
        #3 chk("abort_refetch", act_a, e_fetch);
        tick();
        chk("abort_decode", act_a, e_dec);

        // illegal opcode: trap instance sticks, fetch instance returns
        reset = 1'b1; tick(); reset = 1'b0; Op = 6'b111111;
        #3 chk("ill_fetch", act_a, e_fetch);
        tick();
        chk("ill_decode", act_a, e_dec);
        chk("ill_decode_b", act_b, e_dec);
        tick();
        chk("ill_b_refetch", act_b, e_fetch);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("trap_hold%0d", k), act_a, e_trap);
            tick();
        end
        reset = 1'b1;
        #3 chk("trap_cleared", act_a, e_rst);
        tick();

        // R-type with unsupported Funct
        reset = 1'b0; Op = RT; Funct = 6'b000111;
        #3 chk("badf_fetch", act_a, e_fetch);
        tick();
        chk("badf_decode", act_a, e_dec);
        tick();
        chk("badf_trap", act_a, e_trap);
        chk("badf_b_refetch", act_b, e_fetch);
        reset = 1'b1;
        #3 chk("badf_cleared", act_b, e_rst);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
